// File: rtl/multiciclo_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared datapath, 3-5 states per instruction.
// Moore outputs are registered alongside the state; fetch and memory states hold until mem_ready, and reset clears all outputs asynchronously.
module multiciclo_ctrl_fsm #(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               MemtoReg,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC_R  = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    typedef struct packed {
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       in_fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

    state_t state_q, state_d;
    logic   is_store_q, is_store_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   opcode_legal;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.mem_read = 1'b1; c.in_fetch = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE:  c.alu_src_b = 2'b11;
            S_MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:   begin c.mem_read = 1'b1; c.ior_d = 1'b1; end
            S_MEMWB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEMWR:   begin c.mem_write = 1'b1; c.ior_d = 1'b1; end
            S_EXEC_R:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:   begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH:  begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDI_WB: c.reg_write = 1'b1;
            S_JUMP:    begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    assign opcode_legal = (opcode == OP_R)   || (opcode == OP_LW)   || (opcode == OP_SW) ||
                          (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                // IR keeps the opcode; only lw-vs-sw needs remembering past this cycle.
                is_store_d = (opcode == OP_SW);
                if (opcode == OP_R)                          state_d = S_EXEC_R;
                else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
                else if (opcode == OP_ADDI)                  state_d = S_ADDI_EX;
                else if (opcode == OP_J)                     state_d = S_JUMP;
                else                                         state_d = S_FETCH;
            end
            S_MEMADR:  state_d = is_store_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:  state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            ctrl_q     <= ctrl_d;
        end
    end

    // Fetch's IR/PC loads complete only on the cycle memory answers.
    assign IRWrite     = ctrl_q.in_fetch & mem_ready;
    assign PCWrite     = ctrl_q.pc_write | (ctrl_q.in_fetch & mem_ready);
    assign illegal_op  = (state_q == S_DECODE) & ~opcode_legal;

    assign RegDst      = ctrl_q.reg_dst;
    assign RegWrite    = ctrl_q.reg_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign IorD        = ctrl_q.ior_d;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign ALUOp       = ctrl_q.alu_op;
    assign PCSource    = ctrl_q.pc_source;
    assign state_o     = STATE_W'(state_q);

endmodule

// File: tb/tb_multiciclo_ctrl_fsm.sv
// Bench for multiciclo_ctrl_fsm: directed instruction walks with literal expectations, then random opcode/mem_ready/reset traffic.
module tb_multiciclo_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       RegDst, RegWrite, MemtoReg, IorD, MemRead, MemWrite, IRWrite;
    logic       PCWrite, PCWriteCond, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    multiciclo_ctrl_fsm #(.OP_W(6), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [16:0] dut_vec;
    assign dut_vec = {RegDst, RegWrite, MemtoReg, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                      PCWriteCond, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Output table by state number, straight from the control-signal listing.
    function automatic logic [16:0] exp_out(input int s, input logic mr, input logic [5:0] op);
        logic rd, rw, m2r, iord, mrd, mwr, irw, pcw, pcwc, asa, ill;
        logic [1:0] asb, aop, pcs;
        {rd, rw, m2r, iord, mrd, mwr, irw, pcw, pcwc, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            1:  begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
            2:  begin asb = 2'b11; ill = !is_legal(op); end
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin asa = 1; aop = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        return {rd, rw, m2r, iord, mrd, mwr, irw, pcw, pcwc, asa, asb, aop, pcs, ill};
    endfunction

    // Post-decode state path per instruction class; 1 (fetch) once exhausted.
    function automatic int path_at(input logic [5:0] op, input int i);
        int p[3];
        case (op)
            6'b100011: p = '{3, 4, 5};
            6'b101011: p = '{3, 6, 1};
            6'b000000: p = '{7, 8, 1};
            6'b000100: p = '{9, 1, 1};
            6'b001000: p = '{10, 11, 1};
            6'b000010: p = '{12, 1, 1};
            default:   p = '{1, 1, 1};
        endcase
        return (i < 3) ? p[i] : 1;
    endfunction

    function automatic int base_lat(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    int         m_state = 0;
    int         m_step  = 0;
    logic [5:0] m_op    = 6'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 0;
            m_step  <= 0;
        end else if (m_state == 0) begin
            m_state <= 1;
        end else if (m_state == 1) begin
            m_state <= mem_ready ? 2 : 1;
        end else if (m_state == 2) begin
            m_op    <= opcode;
            m_state <= path_at(opcode, 0);
            m_step  <= 1;
        end else if ((m_state == 4 || m_state == 6) && !mem_ready) begin
            m_state <= m_state;
        end else begin
            m_state <= path_at(m_op, m_step);
            m_step  <= m_step + 1;
        end
    end

    initial begin
        int  s, prev_s, lat, stl, base;
        bit  trk;
        prev_s = 0; lat = 0; stl = 0; base = 0; trk = 0;
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("state", 32'(state_o), 32'(m_state));
                chk("outputs", 32'(dut_vec), 32'(exp_out(m_state, mem_ready, opcode)));
                if (reset) begin
                    trk = 0;
                    prev_s = 0;
                end else begin
                    s = int'(state_o);
                    if (s == 1 && prev_s != 1) begin
                        if (trk) chk("latency", 32'(lat), 32'(base + stl));
                        trk = 1; lat = 0; stl = 0; base = 0;
                    end
                    if (trk) begin
                        lat++;
                        if ((s == 1 || s == 4 || s == 6) && !mem_ready) stl++;
                        if (s == 2) base = base_lat(opcode);
                    end
                    prev_s = s;
                end
            end
        end
    end

    task automatic step(input int s);
        @(posedge clk);
        #1;
        chk("state_seq", 32'(state_o), 32'(s));
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_outs", 32'(dut_vec), 32'd0);
        mem_ready = 1'b1;
        reset = 1'b0;
        step(1);
        chk("fetch_irwrite", 32'(IRWrite), 32'd1);
        chk("fetch_pcwrite", 32'(PCWrite), 32'd1);

        opcode = 6'b000000;
        step(2); step(7); step(8);
        chk("aluwb_regdst", 32'(RegDst), 32'd1);
        chk("aluwb_regwrite", 32'(RegWrite), 32'd1);
        chk("aluwb_memtoreg", 32'(MemtoReg), 32'd0);
        step(1);

        opcode = 6'b100011;
        step(2); step(3); step(4);
        mem_ready = 1'b0;
        step(4); step(4);
        mem_ready = 1'b1;
        step(5);
        chk("memwb_regdst", 32'(RegDst), 32'd0);
        chk("memwb_memtoreg", 32'(MemtoReg), 32'd1);
        chk("memwb_regwrite", 32'(RegWrite), 32'd1);
        step(1);

        opcode = 6'b101011;
        step(2); step(3); step(6);
        chk("memwr_memwrite", 32'(MemWrite), 32'd1);
        chk("memwr_regwrite", 32'(RegWrite), 32'd0);
        step(1);
        chk("fetch_memwrite", 32'(MemWrite), 32'd0);

        opcode = 6'b000100;
        step(2); step(9);
        chk("beq_pcwritecond", 32'(PCWriteCond), 32'd1);
        chk("beq_aluop", 32'(ALUOp), 32'd1);
        chk("beq_pcsource", 32'(PCSource), 32'd1);
        step(1);

        opcode = 6'b000010;
        step(2); step(12);
        chk("j_pcwrite", 32'(PCWrite), 32'd1);
        chk("j_pcsource", 32'(PCSource), 32'd2);
        step(1);

        opcode = 6'b111111;
        step(2);
        chk("illegal_pulse", 32'(illegal_op), 32'd1);
        step(1);
        chk("illegal_clear", 32'(illegal_op), 32'd0);

        opcode = 6'b101011;
        step(2); step(3); step(6);
        mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_memwrite", 32'(MemWrite), 32'd0);
        chk("async_rst_state", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        step(1);

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            mem_ready = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 7));
            case (r)
                0: opcode = 6'b000000;
                1: opcode = 6'b100011;
                2: opcode = 6'b101011;
                3: opcode = 6'b000100;
                4: opcode = 6'b001000;
                5: opcode = 6'b000010;
                default: opcode = 6'($urandom_range(0, 63));
            endcase
        end
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
